// File: rtl/stove_pkg.sv
// rtl/stove_pkg.sv - shared constants, types and level clamp for the stove heat scheduler
package stove_pkg;

  localparam int LEVEL_MAX       = 9;
  localparam int SLOTS_PER_FRAME = 9;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  typedef logic [3:0] level_t;

  function automatic level_t clamp_level(input level_t lvl);
    return (lvl > level_t'(LEVEL_MAX)) ? level_t'(LEVEL_MAX) : lvl;
  endfunction

endpackage

// File: rtl/stove_slot_timer.sv
// rtl/stove_slot_timer.sv - slot length counter, ticks in the last cycle of each slot
module stove_slot_timer #(
  parameter int SLOT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic run,
  output logic slot_tick
);

  localparam int            CW   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    slot_tick = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d     = '0;
      slot_tick = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stove_heat_scheduler.sv
// rtl/stove_heat_scheduler.sv - 9-slot burner frame scheduler with round-robin overload arbitration
// Optional STOVE_SCHED_SOFTSTART_EN: latched levels rise by at most one step per frame.
module stove_heat_scheduler
  import stove_pkg::*;
#(
  parameter int SLOT_CYCLES = 5_000_000,
  parameter int MAX_ON      = 1
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       enable,
  input  logic [3:0] level_l,
  input  logic [3:0] level_r,
  output logic       heat_l,
  output logic       heat_r,
  output logic       frame_start,
  output logic [3:0] slot_idx,
  output logic       overload
);

  sched_state_e state_q, state_d;
  level_t       slot_q, slot_d;
  level_t       lat_l_q, lat_l_d, lat_r_q, lat_r_d;
  level_t       srv_l_q, srv_l_d, srv_r_q, srv_r_d;
  logic         ptr_q, ptr_d;
  logic         heat_l_q, heat_l_d, heat_r_q, heat_r_d;
  logic         frame_start_q, frame_start_d;
  logic         overload_q, overload_d;

  logic         run, slot_tick, frame_begin, slot_adv;
  level_t       lvl_l_c, lvl_r_c, lat_l_new, lat_r_new, lat_l_eff, lat_r_eff;
  level_t       srv_l_base, srv_r_base;
  logic         need_l, need_r, ptr_base, grant_l, grant_r, ptr_next;
  logic [4:0]   lat_sum;
  logic         overload_new;

  assign run = (state_q == ST_RUN) && enable;

  stove_slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_slot_timer (
    .clk         (clk),
    .async_nreset(async_nreset),
    .run         (run),
    .slot_tick   (slot_tick)
  );

  assign lvl_l_c = clamp_level(level_l);
  assign lvl_r_c = clamp_level(level_r);

`ifdef STOVE_SCHED_SOFTSTART_EN
  assign lat_l_new = (lvl_l_c > lat_l_q + 4'd1) ? lat_l_q + 4'd1 : lvl_l_c;
  assign lat_r_new = (lvl_r_c > lat_r_q + 4'd1) ? lat_r_q + 4'd1 : lvl_r_c;
`else
  assign lat_l_new = lvl_l_c;
  assign lat_r_new = lvl_r_c;
`endif

  assign frame_begin = enable && ((state_q == ST_IDLE) ||
                       (slot_tick && (slot_q == level_t'(SLOTS_PER_FRAME - 1))));
  assign slot_adv    = enable && slot_tick;

  // Decisions for the next slot use the served counts including the slot now ending.
  assign lat_l_eff  = frame_begin ? lat_l_new : lat_l_q;
  assign lat_r_eff  = frame_begin ? lat_r_new : lat_r_q;
  assign srv_l_base = frame_begin ? '0 : srv_l_q + {3'b000, heat_l_q};
  assign srv_r_base = frame_begin ? '0 : srv_r_q + {3'b000, heat_r_q};
  assign ptr_base   = frame_begin ? LEFT : ptr_q;
  assign need_l     = srv_l_base < lat_l_eff;
  assign need_r     = srv_r_base < lat_r_eff;

  always_comb begin
    grant_l  = need_l;
    grant_r  = need_r;
    ptr_next = ptr_base;
    if ((MAX_ON == 1) && need_l && need_r) begin
      grant_l  = (ptr_base == LEFT);
      grant_r  = (ptr_base == RIGHT);
      ptr_next = ~ptr_base;
    end
  end

  assign lat_sum      = {1'b0, lat_l_eff} + {1'b0, lat_r_eff};
  assign overload_new = (MAX_ON == 1) && (lat_sum > 5'd9);

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    lat_l_d       = lat_l_q;
    lat_r_d       = lat_r_q;
    srv_l_d       = srv_l_q;
    srv_r_d       = srv_r_q;
    ptr_d         = ptr_q;
    heat_l_d      = heat_l_q;
    heat_r_d      = heat_r_q;
    frame_start_d = 1'b0;
    overload_d    = overload_q;
    if (!enable) begin
      state_d    = ST_IDLE;
      slot_d     = '0;
      lat_l_d    = '0;
      lat_r_d    = '0;
      srv_l_d    = '0;
      srv_r_d    = '0;
      ptr_d      = LEFT;
      heat_l_d   = 1'b0;
      heat_r_d   = 1'b0;
      overload_d = 1'b0;
    end else if (frame_begin || slot_adv) begin
      state_d       = ST_RUN;
      slot_d        = frame_begin ? '0 : slot_q + 4'd1;
      lat_l_d       = lat_l_eff;
      lat_r_d       = lat_r_eff;
      srv_l_d       = srv_l_base;
      srv_r_d       = srv_r_base;
      ptr_d         = ptr_next;
      heat_l_d      = grant_l;
      heat_r_d      = grant_r;
      frame_start_d = frame_begin;
      if (frame_begin) begin
        overload_d = overload_new;
      end
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q       <= ST_IDLE;
      slot_q        <= '0;
      lat_l_q       <= '0;
      lat_r_q       <= '0;
      srv_l_q       <= '0;
      srv_r_q       <= '0;
      ptr_q         <= LEFT;
      heat_l_q      <= 1'b0;
      heat_r_q      <= 1'b0;
      frame_start_q <= 1'b0;
      overload_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      lat_l_q       <= lat_l_d;
      lat_r_q       <= lat_r_d;
      srv_l_q       <= srv_l_d;
      srv_r_q       <= srv_r_d;
      ptr_q         <= ptr_d;
      heat_l_q      <= heat_l_d;
      heat_r_q      <= heat_r_d;
      frame_start_q <= frame_start_d;
      overload_q    <= overload_d;
    end
  end

  assign heat_l      = heat_l_q;
  assign heat_r      = heat_r_q;
  assign frame_start = frame_start_q;
  assign slot_idx    = slot_q;
  assign overload    = overload_q;

endmodule

// File: tb/tb_stove_heat_scheduler.sv
// tb/tb_stove_heat_scheduler.sv - directed bench, MAX_ON=1 and MAX_ON=2 instances on shared stimulus
module tb_stove_heat_scheduler;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       async_nreset;
  logic       enable;
  logic [3:0] level_l, level_r;

  logic       h1_l, h1_r, fs1, ov1;
  logic [3:0] si1;
  logic       h2_l, h2_r, fs2, ov2;
  logic [3:0] si2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stove_heat_scheduler #(.SLOT_CYCLES(SC), .MAX_ON(1)) u_dut1 (
    .clk(clk), .async_nreset(async_nreset), .enable(enable),
    .level_l(level_l), .level_r(level_r),
    .heat_l(h1_l), .heat_r(h1_r), .frame_start(fs1), .slot_idx(si1), .overload(ov1)
  );

  stove_heat_scheduler #(.SLOT_CYCLES(SC), .MAX_ON(2)) u_dut2 (
    .clk(clk), .async_nreset(async_nreset), .enable(enable),
    .level_l(level_l), .level_r(level_r),
    .heat_l(h2_l), .heat_r(h2_r), .frame_start(fs2), .slot_idx(si2), .overload(ov2)
  );

  task automatic expect_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input string tag);
    expect_eq({tag, " d1 heat_l"}, 16'(h1_l), 16'd0);
    expect_eq({tag, " d1 heat_r"}, 16'(h1_r), 16'd0);
    expect_eq({tag, " d1 slot"},   16'(si1),  16'd0);
    expect_eq({tag, " d1 fs"},     16'(fs1),  16'd0);
    expect_eq({tag, " d1 ovl"},    16'(ov1),  16'd0);
    expect_eq({tag, " d2 heat_l"}, 16'(h2_l), 16'd0);
    expect_eq({tag, " d2 heat_r"}, 16'(h2_r), 16'd0);
    expect_eq({tag, " d2 slot"},   16'(si2),  16'd0);
  endtask

  // Called at the negedge just before slot 0 of a frame; returns at the last negedge of slot 8.
  task automatic run_frame(input string tag,
                           input logic [8:0] l1, input logic [8:0] r1, input logic o1,
                           input logic [8:0] l2, input logic [8:0] r2,
                           input int chg_slot, input logic [3:0] chg_r);
    int cl1 = 0, cr1 = 0, cl2 = 0, cr2 = 0, both = 0, fsn1 = 0, fsn2 = 0;
    for (int s = 0; s < 9; s++) begin
      for (int c = 0; c < SC; c++) begin
        @(negedge clk);
        if (s == chg_slot && c == 1) level_r = chg_r;
        cl1  += int'(h1_l);
        cr1  += int'(h1_r);
        cl2  += int'(h2_l);
        cr2  += int'(h2_r);
        both += int'(h1_l & h1_r);
        fsn1 += int'(fs1);
        fsn2 += int'(fs2);
        if (c == 0) begin
          expect_eq($sformatf("%s s%0d d1 heat_l", tag, s), 16'(h1_l), 16'(l1[s]));
          expect_eq($sformatf("%s s%0d d1 heat_r", tag, s), 16'(h1_r), 16'(r1[s]));
          expect_eq($sformatf("%s s%0d d1 slot", tag, s),   16'(si1),  16'(s));
          expect_eq($sformatf("%s s%0d d1 ovl", tag, s),    16'(ov1),  16'(o1));
          expect_eq($sformatf("%s s%0d d2 heat_l", tag, s), 16'(h2_l), 16'(l2[s]));
          expect_eq($sformatf("%s s%0d d2 heat_r", tag, s), 16'(h2_r), 16'(r2[s]));
          expect_eq($sformatf("%s s%0d d2 slot", tag, s),   16'(si2),  16'(s));
          expect_eq($sformatf("%s s%0d d2 ovl", tag, s),    16'(ov2),  16'd0);
          if (s == 0) begin
            expect_eq($sformatf("%s d1 fs first", tag), 16'(fs1), 16'd1);
            expect_eq($sformatf("%s d2 fs first", tag), 16'(fs2), 16'd1);
          end
        end
      end
    end
    expect_eq({tag, " d1 heat_l cycles"}, 16'(cl1), 16'(SC * $countones(l1)));
    expect_eq({tag, " d1 heat_r cycles"}, 16'(cr1), 16'(SC * $countones(r1)));
    expect_eq({tag, " d2 heat_l cycles"}, 16'(cl2), 16'(SC * $countones(l2)));
    expect_eq({tag, " d2 heat_r cycles"}, 16'(cr2), 16'(SC * $countones(r2)));
    expect_eq({tag, " d1 both on"},       16'(both), 16'd0);
    expect_eq({tag, " d1 fs cycles"},     16'(fsn1), 16'd1);
    expect_eq({tag, " d2 fs cycles"},     16'(fsn2), 16'd1);
  endtask

  initial begin
    async_nreset = 1'b0;
    enable       = 1'b0;
    level_l      = 4'd0;
    level_r      = 4'd0;
    #12;
    expect_idle("reset");
    @(negedge clk);
    async_nreset = 1'b1;
    repeat (3) @(negedge clk);
    expect_idle("idle");

`ifdef STOVE_SCHED_SOFTSTART_EN
    level_l = 4'd4;
    enable  = 1'b1;
    run_frame("ss1", 9'h001, 9'h000, 1'b0, 9'h001, 9'h000, -1, 4'd0);
    run_frame("ss2", 9'h003, 9'h000, 1'b0, 9'h003, 9'h000, -1, 4'd0);
    run_frame("ss3", 9'h007, 9'h000, 1'b0, 9'h007, 9'h000, -1, 4'd0);
    run_frame("ss4", 9'h00F, 9'h000, 1'b0, 9'h00F, 9'h000, -1, 4'd0);
    level_l = 4'd1;
    run_frame("ssd", 9'h001, 9'h000, 1'b0, 9'h001, 9'h000, -1, 4'd0);
`else
    level_l = 4'd3;
    level_r = 4'd4;
    enable  = 1'b1;
    run_frame("a0", 9'h015, 9'h06A, 1'b0, 9'h007, 9'h00F, -1, 4'd0);
    run_frame("a1", 9'h015, 9'h06A, 1'b0, 9'h007, 9'h00F, -1, 4'd0);

    level_l = 4'd7;
    level_r = 4'd6;
    run_frame("b0", 9'h155, 9'h0AA, 1'b1, 9'h07F, 9'h03F, -1, 4'd0);

    level_l = 4'd12;
    level_r = 4'd0;
    run_frame("c0", 9'h1FF, 9'h000, 1'b0, 9'h1FF, 9'h000, 3, 4'd5);
    run_frame("c1", 9'h155, 9'h0AA, 1'b1, 9'h1FF, 9'h01F, -1, 4'd0);

    repeat (21) @(negedge clk);
    expect_eq("drop d1 slot before", 16'(si1), 16'd5);
    enable = 1'b0;
    @(negedge clk);
    expect_idle("drop");
    enable = 1'b1;
    @(negedge clk);
    expect_eq("reen d1 fs",     16'(fs1),  16'd1);
    expect_eq("reen d1 slot",   16'(si1),  16'd0);
    expect_eq("reen d1 heat_l", 16'(h1_l), 16'd1);
    expect_eq("reen d1 heat_r", 16'(h1_r), 16'd0);
    expect_eq("reen d1 ovl",    16'(ov1),  16'd1);
    expect_eq("reen d2 fs",     16'(fs2),  16'd1);
    expect_eq("reen d2 heat_r", 16'(h2_r), 16'd1);

    repeat (6) @(negedge clk);
    expect_eq("prerst d1 heat_r", 16'(h1_r), 16'd1);
    #2;
    async_nreset = 1'b0;
    #1;
    expect_idle("async rst");
    level_l = 4'd3;
    level_r = 4'd4;
    @(negedge clk);
    async_nreset = 1'b1;
    run_frame("e0", 9'h015, 9'h06A, 1'b0, 9'h007, 9'h00F, -1, 4'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stove_heat_scheduler.md
# stove_heat_scheduler

Time-slot scheduler that turns the two burner power levels (0–9) selected by the stove front-panel controller into on/off drive for the two heating elements. Each frame has 9 slots, and each burner is driven for as many slots as its level. When the supply cannot run both elements at once, the block arbitrates contested slots round-robin and flags an overload. It sits between the panel controller's power registers and the element drivers.

## Interface
- SLOT_CYCLES, default 5_000_000: clock cycles per slot (100 ms at 50 MHz); legal range ≥ 2.
- MAX_ON, default 1: maximum elements energised simultaneously; legal values 1 or 2.
- clk  in  1  system clock.
- async_nreset  in  1  reset, asynchronous, active-low.
- enable  in  1  stove on; low forces IDLE.
- level_l  in  4  requested left level; values > 9 are clamped to 9.
- level_r  in  4  requested right level; values > 9 are clamped to 9.
- heat_l  out  1  left element drive, registered.
- heat_r  out  1  right element drive, registered.
- frame_start  out  1  one-cycle pulse in the first cycle of slot 0.
- slot_idx  out  4  current slot, 0–8; 0 in IDLE.
- overload  out  1  current frame demand exceeds capacity; held for the whole frame.

## Operation
- States: IDLE, RUN.
- IDLE: all outputs 0, slot counters cleared, latched levels 0.
- IDLE → RUN on the first clock edge where enable = 1.
- RUN → IDLE on any edge where enable = 0. Outputs are 0 from that edge on, with no frame completion.
- Frame start (entry to RUN, or the slot-8 → slot-0 wrap):
  - latch clamped levels into lat_l and lat_r;
  - clear the served counters srv_l and srv_r;
  - reset the round-robin pointer to LEFT;
  - compute overload = (MAX_ON == 1) && (lat_l + lat_r > 9), using a 5-bit sum.
- Per slot, need_x = (srv_x < lat_x).
- MAX_ON = 2: heat_x = need_x.
- MAX_ON = 1:
  - if exactly one burner needs the slot, it is granted;
  - if both need it, the pointer side is granted and the pointer toggles;
  - the pointer toggles only on contested slots.
- The granted side's srv increments at the slot boundary.
- Unserved demand at frame end is dropped. It never carries into the next frame.
- Level changes mid-frame are ignored until the next frame start.
- heat_l and heat_r are never both 1 when MAX_ON = 1.

## Timing
- Reset value of every output is 0. Reset mid-frame returns to IDLE immediately; the round-robin pointer resets to LEFT.
- Enable→drive latency: at the first edge with enable = 1, slot 0 begins.
  - heat, frame_start and overload are valid in the cycle after that edge.
  - Levels are sampled at that same edge.
- Each slot is exactly SLOT_CYCLES cycles. heat_* and slot_idx change only at slot boundaries.
- Frame period is 9 × SLOT_CYCLES cycles. frame_start is high for exactly 1 cycle per frame.
- Scheduling decisions for slot n+1 are made combinationally from srv/lat and registered at the boundary. There is no extra latency.

## Configuration
- STOVE_SCHED_SOFTSTART_EN:
  - Defined: at each frame start, lat_x = min(clamped level_x, previous lat_x + 1). Decreases apply immediately, and lat is 0 after IDLE. A 0→9 request therefore reaches 9 on the ninth frame.
  - Undefined: lat_x = clamped level_x directly.
  - overload is computed on the effective lat values in both cases.

## Structure
- Shared package stove_pkg holds:
  - LEVEL_MAX = 9 and SLOTS_PER_FRAME = 9;
  - LEFT/RIGHT index constants;
  - the scheduler state enum (IDLE, RUN);
  - the 4-bit level type.
- Sub-module stove_slot_timer:
  - ports: clk, async_nreset, run, slot_tick;
  - counts SLOT_CYCLES, emits a 1-cycle tick at the last cycle of each slot, and clears when run = 0.
- The top level holds the FSM, slot index, latches, served counters, pointer and output registers.

## Test plan
- MAX_ON = 1, SLOT_CYCLES = 4, levels 3/4 → heat_l in slots 0, 2, 4; heat_r in slots 1, 3, 5, 6; slots 7–8 off; overload = 0; pattern repeats each frame with frame_start every 36 cycles.
- MAX_ON = 1, levels 7/6 → alternating L/R in slots 0–8 (L gets 5, R gets 4); overload = 1 for the whole frame; heat_l & heat_r is never 1.
- MAX_ON = 2, levels 9/0, then level_r changed to 5 in mid-frame slot 3 → this frame heat_l on all 9 slots and heat_r 0; next frame heat_r on in slots 0–4.
- level_l = 12 → treated as 9. enable dropped in slot 5 → all outputs 0 on the next edge. Re-enable → frame_start pulse and slot_idx = 0.
- async_nreset asserted mid-slot → outputs 0 immediately. After release with enable = 1, the first frame starts on the first edge.
- SOFTSTART_EN defined, level_l stepped 0→4 → lat_l = 1, 2, 3, 4 over four consecutive frames (heat_l slot counts 1, 2, 3, 4). Then 4→1 → next frame 1 slot.
